// File: rtl/seg7_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_reader
//  Purpose  : Recovers the four digits shown on a multiplexed, scanned
//             7-segment display. The {dig_en, seg} pair is sampled each
//             cycle. A digit is captured only after STABLE_CYCLES identical
//             samples, and is then decoded to BCD. Blank digits are stored
//             as 4'hF. Unrecognised patterns are stored as 4'hE and raise
//             err.
//  Ports    : clk         - clock, rising edge
//             rst_n       - asynchronous active-low reset
//             seg[6:0]    - segment bus, bit6=a .. bit0=g, active-high
//             dig_en[3:0] - digit enables, one-hot, bit0 = rightmost digit
//             err_clr     - synchronous clear of err_sticky
//             bcd_out     - captured digits, nibble i = digit i
//             digit_valid - bit i set when nibble i holds 0..9
//             frame_done  - pulse when all four digits have been captured
//             err         - pulse on capture of an unrecognised pattern
//             err_sticky  - latched err until err_clr
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_en,
    input  logic        err_clr,
    output logic [15:0] bcd_out,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        err,
    output logic        err_sticky
);

    localparam logic [7:0] c_stable = 8'(STABLE_CYCLES);
    localparam logic [7:0] c_stable_m1 = 8'(STABLE_CYCLES - 1);

    logic [10:0] r_sample;
    logic [7:0]  r_cnt;
    logic [3:0]  r_mask;
    logic [15:0] r_bcd;
    logic [3:0]  r_valid;
    logic        r_frame_done;
    logic        r_err;
    logic        r_err_sticky;

    logic [10:0] w_in;
    logic        w_same;
    logic [3:0]  w_den;
    logic        w_onehot;
    logic        w_capture;
    logic [3:0]  w_nibble;
    logic        w_is_dec;
    logic        w_is_err;
    logic [3:0]  w_mask_or;
    logic        w_frame;

    assign w_in   = {dig_en, seg};
    assign w_same = (w_in == r_sample);
    assign w_den  = r_sample[10:7];
    // A power of two has exactly one bit set, so x & (x-1) is zero.
    assign w_onehot = (w_den != 4'd0) && ((w_den & (w_den - 4'd1)) == 4'd0);

    // A capture happens only on the edge that takes the counter to
    // saturation. Once saturated, the counter stays there, so a held
    // pattern is captured only once.
    assign w_capture = w_same && (r_cnt == c_stable_m1) && w_onehot;

    always_comb begin
        w_nibble = 4'hE;
        w_is_dec = 1'b1;
        w_is_err = 1'b0;
        case (r_sample[6:0])
            7'b1111110: w_nibble = 4'd0;
            7'b0110000: w_nibble = 4'd1;
            7'b1101101: w_nibble = 4'd2;
            7'b1111001: w_nibble = 4'd3;
            7'b0110011: w_nibble = 4'd4;
            7'b1011011: w_nibble = 4'd5;
            7'b0011111: w_nibble = 4'd6;
            7'b1110000: w_nibble = 4'd7;
            7'b1111111: w_nibble = 4'd8;
            7'b1110011: w_nibble = 4'd9;
            7'b0000000: begin
                w_nibble = 4'hF;
                w_is_dec = 1'b0;
            end
            default: begin
                w_nibble = 4'hE;
                w_is_dec = 1'b0;
                w_is_err = 1'b1;
            end
        endcase
    end

    assign w_mask_or = r_mask | w_den;
    assign w_frame   = w_capture && (w_mask_or == 4'hF);

    // Sample register and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= 11'd0;
            r_cnt    <= 8'd0;
        end else begin
            r_sample <= w_in;
            if (!w_same) begin
                r_cnt <= 8'd1;
            end else if (r_cnt < c_stable) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // Captured digits, frame tracking and error reporting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask       <= 4'd0;
            r_bcd        <= 16'hFFFF;
            r_valid      <= 4'd0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_frame_done <= w_frame;
            r_err        <= w_capture && w_is_err;
            if (w_capture) begin
                r_mask <= w_frame ? 4'd0 : w_mask_or;
                for (int i = 0; i < 4; i++) begin
                    if (w_den[i]) begin
                        r_bcd[i*4 +: 4] <= w_nibble;
                        r_valid[i]      <= w_is_dec;
                    end
                end
            end
            // A new error outranks a simultaneous clear.
            if (w_capture && w_is_err) begin
                r_err_sticky <= 1'b1;
            end else if (err_clr) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    assign bcd_out     = r_bcd;
    assign digit_valid = r_valid;
    assign frame_done  = r_frame_done;
    assign err         = r_err;
    assign err_sticky  = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_reader
//  Purpose  : Directed self-checking bench for seg7_scan_reader
//             (STABLE_CYCLES = 4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_reader;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic        err_clr;
    logic [15:0] bcd_out;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;
    logic        err_sticky;

    int passed = 0;
    int total  = 0;

    seg7_scan_reader #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .dig_en      (dig_en),
        .err_clr     (err_clr),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err),
        .err_sticky  (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] e_bcd, input logic [3:0] e_val,
                           input logic e_fd, input logic e_err, input logic e_st);
        chk({tag, ".bcd"}, bcd_out, e_bcd);
        chk({tag, ".valid"}, {12'd0, digit_valid}, {12'd0, e_val});
        chk({tag, ".frame_done"}, {15'd0, frame_done}, {15'd0, e_fd});
        chk({tag, ".err"}, {15'd0, err}, {15'd0, e_err});
        chk({tag, ".err_sticky"}, {15'd0, err_sticky}, {15'd0, e_st});
    endtask

    task automatic drive(input logic [3:0] d, input logic [6:0] s);
        dig_en = d;
        seg    = s;
    endtask

    initial begin
        rst_n = 1'b0; err_clr = 1'b0; drive(4'b0000, 7'b0000000);
        step(2);
        chk_out("reset", 16'hFFFF, 4'b0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Single digit '2' on digit 0: captured on the 4th edge, only once.
        drive(4'b0001, 7'b1101101);
        step(3);
        chk("d2_before", bcd_out, 16'hFFFF);
        step(1);
        chk_out("d2_cap", 16'hFFF2, 4'b0001, 1'b0, 1'b0, 1'b0);
        step(4);
        chk_out("d2_hold", 16'hFFF2, 4'b0001, 1'b0, 1'b0, 1'b0);

        // Full scan from a fresh frame mask
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        drive(4'b0010, 7'b1111001); step(4);
        chk("scan1.fd", {15'd0, frame_done}, 16'd0); step(1);
        drive(4'b0100, 7'b0110011); step(4);
        chk("scan2.fd", {15'd0, frame_done}, 16'd0); step(1);
        drive(4'b1000, 7'b1111110); step(4);
        chk("scan3.fd", {15'd0, frame_done}, 16'd0); step(1);
        drive(4'b0001, 7'b1011011); step(4);
        chk_out("scan4", 16'h0435, 4'b1111, 1'b1, 1'b0, 1'b0);
        step(1);
        chk("scan4_after.fd", {15'd0, frame_done}, 16'd0);

        // Blank then unrecognised pattern on digit 2
        drive(4'b0100, 7'b0000000); step(4);
        chk_out("blank", 16'h0F35, 4'b1011, 1'b0, 1'b0, 1'b0);
        drive(4'b0100, 7'b1000001); step(3);
        chk("bad_pre.err", {15'd0, err}, 16'd0);
        step(1);
        chk_out("bad", 16'h0E35, 4'b1011, 1'b0, 1'b1, 1'b1);
        step(1);
        chk_out("bad_after", 16'h0E35, 4'b1011, 1'b0, 1'b0, 1'b1);

        // New error coinciding with err_clr keeps sticky set; clear alone clears.
        drive(4'b1000, 7'b1000001); step(3);
        err_clr = 1'b1; step(1);
        chk_out("clr_err", 16'hEE35, 4'b0011, 1'b0, 1'b1, 1'b1);
        step(1);
        chk_out("clr_only", 16'hEE35, 4'b0011, 1'b0, 1'b0, 1'b0);
        err_clr = 1'b0;

        // Unstable pattern, non-one-hot enable and no enable: no capture.
        drive(4'b0001, 7'b1111110); step(3);
        drive(4'b0011, 7'b0110000); step(10);
        chk_out("nocap", 16'hEE35, 4'b0011, 1'b0, 1'b0, 1'b0);
        drive(4'b0000, 7'b1000001); step(6);
        chk_out("noen", 16'hEE35, 4'b0011, 1'b0, 1'b0, 1'b0);

        // Reset mid-count discards the pending capture.
        drive(4'b0001, 7'b0110000); step(3);
        rst_n = 1'b0; #1;
        chk_out("midrst", 16'hFFFF, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("postrst_pre", bcd_out, 16'hFFFF);
        step(1);
        chk_out("postrst", 16'hFFF1, 4'b0001, 1'b0, 1'b0, 1'b0);

        // Recapture of a masked digit does not finish the frame early.
        drive(4'b0001, 7'b0110011); step(4);
        chk_out("recap", 16'hFFF4, 4'b0001, 1'b0, 1'b0, 1'b0);
        drive(4'b0010, 7'b1111111); step(4);
        chk("f2.fd", {15'd0, frame_done}, 16'd0);
        drive(4'b0100, 7'b0000000); step(4);
        chk("f3.fd", {15'd0, frame_done}, 16'd0);
        drive(4'b1000, 7'b1110011); step(4);
        chk_out("f4", 16'h9F84, 4'b1011, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_reader.md
SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 The block SHALL have one parameter: STABLE_CYCLES, default 4, the number of consecutive identical samples required before a digit is accepted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 seg  input  7  multiplexed segment bus, bit6=a .. bit0=g, active-high.
REQ-005 dig_en  input  4  digit enables, active-high, expected one-hot; bit0 = rightmost digit.
REQ-006 err_clr  input  1  synchronous clear of err_sticky.
REQ-007 bcd_out  output  16  captured digits, nibble i = digit i.
REQ-008 digit_valid  output  4  bit i set when nibble i holds a decimal value 0..9.
REQ-009 frame_done  output  1  one-cycle pulse when all four digits have been captured since the previous pulse.
REQ-010 err  output  1  one-cycle pulse on capture of an unrecognized segment pattern.
REQ-011 err_sticky  output  1  latched err until err_clr.

Function
REQ-012 The block SHALL register {dig_en, seg} every cycle into a sample register S.
REQ-013 The stability counter SHALL load 1 when the incoming pair differs from S, increment when equal, and saturate at STABLE_CYCLES.
REQ-014 A capture SHALL occur on the edge where the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES; at most one capture per held pattern, none while saturated.
REQ-015 Latency: inputs changed before edge 1 and held SHALL be reflected in outputs immediately after edge STABLE_CYCLES (edge 4 at default).
REQ-016 Capture SHALL be suppressed (no output change, counter still runs) when dig_en is 0000 or not one-hot.
REQ-017 Decode table (seg -> nibble): 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 0011111->6, 1110000->7, 1111111->8, 1110011->9; a decimal capture SHALL set digit_valid[i].
REQ-018 Pattern 0000000 (blank) SHALL store 4'hF, clear digit_valid[i], and not raise err.
REQ-019 Any other pattern SHALL store 4'hE, clear digit_valid[i], and pulse err for one cycle on the capture edge.
REQ-020 Every capture (decimal, blank or error) SHALL set bit i of an internal frame mask.
REQ-021 When a capture completes the mask (1111), frame_done SHALL pulse on that same edge and the mask SHALL clear to 0000 on that edge.
REQ-022 Recapturing an already-masked digit SHALL update its nibble but not affect frame_done.
REQ-023 err_sticky SHALL set on any err pulse and clear on err_clr; simultaneous err and err_clr SHALL leave err_sticky set.
REQ-024 Non-captured nibbles and valid bits SHALL hold their values indefinitely.

Reset
REQ-025 While rst_n=0: S=0, counter=0, frame mask=0000, bcd_out=16'hFFFF, digit_valid=0000, frame_done=0, err=0, err_sticky=0.
REQ-026 Reset asserted mid-count SHALL discard the pending capture; after release, counting restarts from the first sample.
REQ-027 Reset release SHALL take effect only at a rising edge; the first post-reset sample is taken at that edge.

Verification
REQ-028 dig_en=0001, seg=1101101 held 4 cycles -> after 4th edge bcd_out[3:0]=2, digit_valid=0001, err=0; holding longer produces no further capture.
REQ-029 Scan 0010/1111001, 0100/0110011, 1000/1111110, 0001/1011011, each held 5 cycles -> bcd_out=16'h0435 (digit3..0 = 0,4,3,5), digit_valid=1111, frame_done pulses once on the capture of digit 0.
REQ-030 dig_en=0100, seg=0000000 held 4 cycles -> nibble2=F, digit_valid[2]=0, err=0; then seg=1000001 held 4 cycles -> nibble2=E, err pulses once, err_sticky=1.
REQ-031 Pattern held 3 cycles then changed (STABLE_CYCLES=4) -> no capture; dig_en=0011 held 10 cycles -> no capture.
REQ-032 err_sticky=1 with err_clr asserted on the same edge as a new err pulse -> err_sticky stays 1; err_clr alone next cycle -> err_sticky=0.
REQ-033 rst_n pulled low after 3 stable cycles -> outputs return to reset values immediately; after release, capture requires 4 new stable cycles.
